fb_pingpong_ctrl: RTL and testbench

FB_PINGPONG_CTRL -- requirements
Module: fb_pingpong_ctrl

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_start_timer.sv | 43 ++++
 rtl/fb_pingpong_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_fb_pingpong_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the ping-pong frame buffer controller.
// Holds the default geometry/timing values and the writer/reader state
// encodings used by fb_pingpong_ctrl and fb_start_timer.
package fb_pkg;

  localparam int FB_FRAME_PIXELS = 4096;
  localparam int FB_ADDR_W       = 12;
  localparam int FB_START_DLY    = 16;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_START = 2'b01,
    R_RUN   = 2'b10
  } rd_state_e;

endpackage

// File: rtl/fb_start_timer.sv
// fb_start_timer -- one-shot delay used between frame selection and the
// first dsi_start.
// Ports:
//   clock_i  : clock, rising edge
//   reset_i  : asynchronous active-high reset
//   load_i   : (re)arms the timer; expire_o follows DLY cycles later
//   expire_o : high for exactly one cycle, in the DLY-th cycle after load
module fb_start_timer
  import fb_pkg::*;
#(
  parameter int DLY = FB_START_DLY
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = (DLY > 1) ? $clog2(DLY) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  // Countdown register; counts DLY-1 down to 0 so the final value marks expiry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= CNT_W'(DLY - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign expire_o = active_q & (cnt_q == '0);

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// fb_pingpong_ctrl -- double-buffered (ping-pong) frame buffer controller.
// A writer fills one bank pixel by pixel while a DSI reader displays the
// other; banks swap at reader end-of-frame once the writer has a full frame.
// Ports:
//   clock_i, reset_i   : clock (rising edge), async active-high reset
//   enable_i           : display path enable
//   wr_pix_en_i        : pixel presented this cycle
//   wr_ready_o         : writer accepting pixels
//   wr_bank_o/wr_addr_o: writer bank and pixel address
//   wr_frame_done_o    : pulse on the final pixel of a frame (same cycle)
//   rd_frame_end_i     : end-of-frame pulse from the DSI controller
//   rd_bank_o          : bank being displayed
//   dsi_start_o        : frame start pulse to the DSI controller
//   pipe_flush_o       : pipeline flush pulse on any enable edge
//   wr_overrun_o       : sticky, a pixel arrived while wr_ready_o was low
//   frame_cnt_o        : bank swap counter, wraps at 256
module fb_pingpong_ctrl
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int START_DLY    = FB_START_DLY
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              wr_pix_en_i,
  output logic              wr_ready_o,
  output logic              wr_bank_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_frame_done_o,
  input  logic              rd_frame_end_i,
  output logic              rd_bank_o,
  output logic              dsi_start_o,
  output logic              pipe_flush_o,
  output logic              wr_overrun_o,
  output logic [7:0]        frame_cnt_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              overrun_q, overrun_d;
  logic              dsi_start_q, dsi_start_d;
  logic              pipe_flush_q, pipe_flush_d;
  logic              enable_q;

  logic en_fall_s, en_rise_s, wr_accept_s, wr_last_s, wr_done_s;
  logic rd_free_s, timer_load_s, timer_expire_s;

  assign en_fall_s   = enable_q & ~enable_i;
  assign en_rise_s   = ~enable_q & enable_i;
  assign wr_accept_s = wr_pix_en_i & (wr_state_q == W_FILL);
  assign wr_last_s   = (wr_addr_q == LAST_ADDR);
  assign wr_done_s   = wr_accept_s & wr_last_s;

  fb_start_timer #(.DLY(START_DLY)) u_start_timer (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load_i   (timer_load_s),
    .expire_o (timer_expire_s)
  );

  // Reader FSM; rd_free_s flags the cycle in which the displayed bank is released.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_bank_d    = rd_bank_q;
    frame_cnt_d  = frame_cnt_q;
    dsi_start_d  = 1'b0;
    rd_free_s    = 1'b0;
    timer_load_s = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (enable_i && (full_q != 2'b00)) begin
          rd_state_d   = R_START;
          rd_bank_d    = ~full_q[0];   // bank 0 wins when both are full
          timer_load_s = 1'b1;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_START: begin
        if (!enable_i) begin
          rd_state_d = R_IDLE;
        end else if (timer_expire_s) begin
          rd_state_d  = R_RUN;
          dsi_start_d = 1'b1;
        end else begin
          rd_state_d = R_START;
        end
      end
      R_RUN: begin
        if (rd_frame_end_i) begin
          if (!enable_i) begin
            rd_state_d = R_IDLE;
            rd_free_s  = 1'b1;
          end else begin
            dsi_start_d = 1'b1;
            // registered full bit: a frame finishing this cycle waits a frame
            if (full_q[~rd_bank_q]) begin
              rd_bank_d   = ~rd_bank_q;
              frame_cnt_d = frame_cnt_q + 8'd1;
              rd_free_s   = 1'b1;
            end else begin
              rd_bank_d = rd_bank_q;
            end
          end
        end else begin
          rd_state_d = R_RUN;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Writer FSM, bank occupancy and sticky overrun.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    full_d       = full_q;
    overrun_d    = overrun_q | (wr_pix_en_i & (wr_state_q == W_WAIT));
    pipe_flush_d = en_fall_s | en_rise_s;

    if (wr_done_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d = full_q;
    end
    if (rd_free_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d = full_d;
    end
    // disable discards any frame queued behind the displayed one
    if (en_fall_s) begin
      full_d[~rd_bank_q] = 1'b0;
    end else begin
      full_d = full_d;
    end

    if (en_fall_s) begin
      wr_addr_d  = '0;
      wr_state_d = W_FILL;
      wr_bank_d  = (rd_state_q == R_RUN) ? ~rd_bank_q : 1'b0;
    end else begin
      case (wr_state_q)
        W_FILL: begin
          if (wr_accept_s) begin
            if (wr_last_s) begin
              wr_addr_d = '0;
              if (((rd_state_q != R_IDLE) && (wr_bank_q != rd_bank_q)) || full_q[~wr_bank_q]) begin
                wr_state_d = W_WAIT;
              end else begin
                wr_bank_d = ~wr_bank_q;
              end
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end
        W_WAIT: begin
          if (rd_free_s) begin
            wr_state_d = W_FILL;
            wr_bank_d  = rd_bank_q;
          end else begin
            wr_state_d = W_WAIT;
          end
        end
        default: wr_state_d = W_FILL;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_state_q   <= W_FILL;
      rd_state_q   <= R_IDLE;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      full_q       <= 2'b00;
      rd_bank_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
      overrun_q    <= 1'b0;
      dsi_start_q  <= 1'b0;
      pipe_flush_q <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      full_q       <= full_d;
      rd_bank_q    <= rd_bank_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      dsi_start_q  <= dsi_start_d;
      pipe_flush_q <= pipe_flush_d;
      enable_q     <= enable_i;
    end
  end

  assign wr_ready_o      = (wr_state_q == W_FILL);
  assign wr_bank_o       = wr_bank_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_frame_done_o = wr_done_s;
  assign rd_bank_o       = rd_bank_q;
  assign dsi_start_o     = dsi_start_q;
  assign pipe_flush_o    = pipe_flush_q;
  assign wr_overrun_o    = overrun_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Testbench for fb_pingpong_ctrl: directed scenarios plus random traffic,
// all checked cycle by cycle against a bank-occupancy reference model.
module tb_fb_pingpong_ctrl;

  localparam int FP = 64;
  localparam int AW = 6;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          rst, en, pix, fe;
  logic          wr_ready, wr_bank, wr_frame_done, rd_bank, dsi_start, pipe_flush, wr_overrun;
  logic [AW-1:0] wr_addr;
  logic [7:0]    frame_cnt;
  logic [19:0]   dut_vec;

  always #5 clk = ~clk;

  fb_pingpong_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW), .START_DLY(SD)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .wr_pix_en_i(pix),
    .wr_ready_o(wr_ready), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr),
    .wr_frame_done_o(wr_frame_done), .rd_frame_end_i(fe), .rd_bank_o(rd_bank),
    .dsi_start_o(dsi_start), .pipe_flush_o(pipe_flush), .wr_overrun_o(wr_overrun),
    .frame_cnt_o(frame_cnt)
  );

  assign dut_vec = {wr_ready, wr_bank, wr_addr, rd_bank, dsi_start, pipe_flush, wr_overrun, frame_cnt};

  int total = 0;
  int bad   = 0;

  // Reference model: what each bank holds and what each side is doing.
  bit       m_wfill;   // writer accepting pixels
  bit       m_wbank;
  int       m_waddr;
  bit [1:0] m_full;
  int       m_rmode;   // 0 idle, 1 waiting for start delay, 2 displaying
  int       m_rcount;  // start-delay cycles still to go
  bit       m_rbank;
  int       m_fcnt;
  bit       m_ovr, m_dsi, m_flush, m_enp;

  function automatic logic [19:0] exp_vec();
    logic [AW-1:0] a;
    logic [7:0]    c;
    a = m_waddr[AW-1:0];
    c = m_fcnt[7:0];
    return {m_wfill, m_wbank, a, m_rbank, m_dsi, m_flush, m_ovr, c};
  endfunction

  function automatic bit exp_done();
    return pix && m_wfill && (m_waddr == FP - 1);
  endfunction

  task automatic model_reset();
    m_wfill = 1; m_wbank = 0; m_waddr = 0; m_full = 2'b00;
    m_rmode = 0; m_rcount = 0; m_rbank = 0; m_fcnt = 0;
    m_ovr = 0; m_dsi = 0; m_flush = 0; m_enp = 0;
  endtask

  task automatic model_edge(input bit e, input bit p, input bit f);
    bit fall, rise, done, orb, owb;
    bit [1:0] nfull;
    int omode, freed;
    fall  = m_enp && !e;
    rise  = !m_enp && e;
    done  = p && m_wfill && (m_waddr == FP - 1);
    omode = m_rmode; orb = m_rbank; owb = m_wbank;
    nfull = m_full; freed = -1; m_dsi = 0;
    // reader
    if (omode == 0) begin
      if (e && (m_full != 2'b00)) begin
        m_rmode = 1; m_rbank = m_full[0] ? 1'b0 : 1'b1; m_rcount = SD;
      end
    end else if (omode == 1) begin
      if (!e) m_rmode = 0;
      else begin
        m_rcount--;
        if (m_rcount == 0) begin m_rmode = 2; m_dsi = 1; end
      end
    end else if (f) begin
      if (!e) begin
        m_rmode = 0; freed = orb;
      end else begin
        m_dsi = 1;
        if (m_full[!orb]) begin
          m_rbank = !orb; m_fcnt = (m_fcnt + 1) % 256; freed = orb;
        end
      end
    end
    // writer
    if (p && !m_wfill) m_ovr = 1;
    if (fall) begin
      m_waddr = 0; m_wfill = 1; m_wbank = (omode == 2) ? !orb : 1'b0;
    end else if (m_wfill) begin
      if (p) begin
        if (m_waddr == FP - 1) begin
          m_waddr = 0;
          if ((omode != 0 && owb != orb) || m_full[!owb]) m_wfill = 0;
          else m_wbank = !owb;
        end else m_waddr++;
      end
    end else if (freed >= 0) begin
      m_wfill = 1; m_wbank = freed[0];
    end
    if (done) nfull[owb] = 1'b1;
    if (freed >= 0) nfull[freed] = 1'b0;
    if (fall) nfull[!orb] = 1'b0;
    m_full  = nfull;
    m_flush = fall || rise;
    m_enp   = e;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(en, pix, fe);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] rv;
    rv = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    rst = 1'b1; en = 1'b0; pix = 1'b0; fe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== rv) begin bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, rv); end
    total++;
    if (wr_frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", wr_frame_done); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_frame();
    int seen;
    en = 1'b1; pix = 1'b1; seen = 0;
    for (int i = 0; i < FP; i++) begin
      #1;
      total++;
      if (wr_frame_done !== (i == FP - 1)) begin bad++; $display("FAIL first_done beat %0d: got %b want %b", i + 1, wr_frame_done, (i == FP - 1)); end
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL first_fill: got %h want %h", dut_vec, exp_vec()); end
    end
    pix = 1'b0;
    total++;
    if (dut.full_q !== 2'b01) begin bad++; $display("FAIL first_full: got %b want 01", dut.full_q); end
    for (int k = 1; k <= 40; k++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL first_start: got %h want %h", dut_vec, exp_vec()); end
      if (dsi_start === 1'b1 && seen == 0) seen = k;
    end
    total++;
    if (seen != SD + 1) begin bad++; $display("FAIL first_dsi_delay: got %0d want %0d", seen, SD + 1); end
    total++;
    if ({rd_bank, wr_bank, wr_ready} !== 3'b011) begin bad++; $display("FAIL first_banks: got %b want 011", {rd_bank, wr_bank, wr_ready}); end
  endtask

  task automatic test_swap();
    pix = 1'b1;
    for (int i = 0; i < FP; i++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL swap_fill: got %h want %h", dut_vec, exp_vec()); end
    end
    pix = 1'b0; fe = 1'b1;
    step();
    fe = 1'b0;
    total++;
    if ({rd_bank, frame_cnt, dsi_start, wr_bank, wr_ready} !== {1'b1, 8'd1, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL swap_result: got %b want %b", {rd_bank, frame_cnt, dsi_start, wr_bank, wr_ready}, {1'b1, 8'd1, 1'b1, 1'b0, 1'b1});
    end
    step();
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL swap_after: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_overrun();
    pix = 1'b1;
    for (int i = 0; i < FP + 5; i++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ovr_fill: got %h want %h", dut_vec, exp_vec()); end
    end
    total++;
    if ({wr_ready, wr_addr, wr_overrun} !== {1'b0, 6'd0, 1'b1}) begin
      bad++; $display("FAIL ovr_hold: got %b want %b", {wr_ready, wr_addr, wr_overrun}, {1'b0, 6'd0, 1'b1});
    end
    pix = 1'b0; fe = 1'b1;
    step();
    fe = 1'b0;
    total++;
    if ({wr_ready, wr_bank, rd_bank, frame_cnt} !== {1'b1, 1'b1, 1'b0, 8'd2}) begin
      bad++; $display("FAIL ovr_release: got %b want %b", {wr_ready, wr_bank, rd_bank, frame_cnt}, {1'b1, 1'b1, 1'b0, 8'd2});
    end
  endtask

  task automatic test_coincide();
    pix = 1'b1;
    for (int i = 0; i < FP - 1; i++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL coin_fill: got %h want %h", dut_vec, exp_vec()); end
    end
    fe = 1'b1;
    #1;
    total++;
    if (wr_frame_done !== 1'b1) begin bad++; $display("FAIL coin_done: got %b want 1", wr_frame_done); end
    step();
    pix = 1'b0; fe = 1'b0;
    total++;
    if ({rd_bank, frame_cnt, dsi_start, wr_ready} !== {1'b0, 8'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coin_noswap: got %b want %b", {rd_bank, frame_cnt, dsi_start, wr_ready}, {1'b0, 8'd2, 1'b1, 1'b0});
    end
    repeat (3) step();
    fe = 1'b1;
    step();
    fe = 1'b0;
    total++;
    if ({rd_bank, frame_cnt, wr_ready, wr_bank} !== {1'b1, 8'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coin_swap: got %b want %b", {rd_bank, frame_cnt, wr_ready, wr_bank}, {1'b1, 8'd3, 1'b1, 1'b0});
    end
  endtask

  task automatic test_disable();
    int dsi_seen;
    pix = 1'b1;
    repeat (20) step();
    pix = 1'b0; en = 1'b0;
    step();
    total++;
    if ({pipe_flush, wr_addr, wr_bank, wr_ready} !== {1'b1, 6'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL dis_flush: got %b want %b", {pipe_flush, wr_addr, wr_bank, wr_ready}, {1'b1, 6'd0, 1'b0, 1'b1});
    end
    step();
    total++;
    if (pipe_flush !== 1'b0) begin bad++; $display("FAIL dis_flush_width: got %b want 0", pipe_flush); end
    repeat (5) step();
    fe = 1'b1;
    step();
    fe = 1'b0;
    dsi_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (dsi_start === 1'b1) dsi_seen++;
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL dis_idle: got %h want %h", dut_vec, exp_vec()); end
    end
    total++;
    if (dsi_seen != 0 || dut.rd_state_q !== fb_pkg::R_IDLE) begin
      bad++; $display("FAIL dis_reader: got dsi=%0d state=%0d want dsi=0 state=0", dsi_seen, dut.rd_state_q);
    end
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      pix = ($urandom_range(0, 3) != 0);
      fe  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 399) == 0) en = ~en;
      #1;
      total++;
      if (wr_frame_done !== exp_done()) begin bad++; $display("FAIL rand_done cycle %0d: got %b want %b", c, wr_frame_done, exp_done()); end
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rand_state cycle %0d: got %h want %h", c, dut_vec, exp_vec()); end
    end
    pix = 1'b0; fe = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [19:0] rv;
    rv = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    en = 1'b1; pix = 1'b1;
    repeat (30) step();
    pix = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (dut_vec !== rv) begin bad++; $display("FAIL async_reset: got %h want %h", dut_vec, rv); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    pix = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL async_recover: got %h want %h", dut_vec, exp_vec()); end
    end
    pix = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_swap();
    test_overrun();
    test_coincide();
    test_disable();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
